// File: rtl/ventana_3x3_pkg.sv
// Shared constants and helpers for the ventana_3x3 cross-window generator.
package ventana_3x3_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/ventana_3x3_linea_buffer.sv
// One image row of pixel storage, addressed by column. The read port shows the
// value stored at the column before this cycle's write replaces it, so the
// old row can be read out while the new row streams in.
module linea_buffer
  import ventana_3x3_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = clog2(IMG_W_DEF)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  // Store the incoming pixel at the current column; contents are never cleared.
  always_ff @(posedge clk) begin
    if (en_i) mem_q[addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/ventana_3x3.sv
// Streams a raster image and emits the 3x3 cross (N/W/C/E/S) around every
// interior pixel, one cycle after the pixel that completes that cross.
module ventana_3x3
  import ventana_3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] e,
  output logic [PIX_W-1:0] f,
  output logic [PIX_W-1:0] h,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic             accept;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] mid_rd, top_rd;
  logic [PIX_W-1:0] top_q, top_d;
  logic [PIX_W-1:0] mid1_q, mid1_d;
  logic [PIX_W-1:0] mid2_q, mid2_d;
  logic [PIX_W-1:0] bot_q, bot_d;
  logic [PIX_W-1:0] b_q, b_d, d_q, d_d, e_q, e_d, f_q, f_d, h_q, h_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;

  // A pixel presented during reset is dropped entirely.
  assign accept = pix_valid & ~rst;

  // Row r-1 comes out of the first buffer while row r goes in.
  linea_buffer #(.DEPTH(IMG_W), .AW(CW)) u_linea_mid (
    .clk       (clk),
    .en_i      (accept),
    .addr_i    (col_q),
    .wr_data_i (pix_in),
    .rd_data_o (mid_rd)
  );

  // Row r-2 comes out of the second buffer while row r-1 cascades in.
  linea_buffer #(.DEPTH(IMG_W), .AW(CW)) u_linea_top (
    .clk       (clk),
    .en_i      (accept),
    .addr_i    (col_q),
    .wr_data_i (mid_rd),
    .rd_data_o (top_rd)
  );

  // Raster position, column delays and the window that pixel (r,c) completes, centred at (r-1,c-1).
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    top_d        = top_q;
    mid1_d       = mid1_q;
    mid2_d       = mid2_q;
    bot_d        = bot_q;
    b_d          = b_q;
    d_d          = d_q;
    e_d          = e_q;
    f_d          = f_q;
    h_d          = h_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      top_d  = top_rd;
      mid1_d = mid_rd;
      mid2_d = mid1_q;
      bot_d  = pix_in;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
        b_d         = top_q;
        d_d         = mid2_q;
        e_d         = mid1_q;
        f_d         = mid_rd;
        h_d         = bot_q;
        win_valid_d = 1'b1;
      end
      frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end
  end

  // State register; reset clears position, delays and every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid1_q       <= '0;
      mid2_q       <= '0;
      bot_q        <= '0;
      b_q          <= '0;
      d_q          <= '0;
      e_q          <= '0;
      f_q          <= '0;
      h_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid1_q       <= mid1_d;
      mid2_q       <= mid2_d;
      bot_q        <= bot_d;
      b_q          <= b_d;
      d_q          <= d_d;
      e_q          <= e_d;
      f_q          <= f_d;
      h_q          <= h_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign b          = b_q;
  assign d          = d_q;
  assign e          = e_q;
  assign f          = f_q;
  assign h          = h_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
